// File: rtl/action_tick_queue.sv
// action_tick_queue
//   Merges NCH free-running periodic timer channels and a user action stream
//   into one ordered action FIFO. The game FSM pops this FIFO one entry at a
//   time.
//
//   When timer actions are pending, they take priority over user actions.
//   Among pending channels, the lowest index wins.
//
//   Optional build macro: ACTQ_COALESCE_EN
//     Drops a timer push when its action equals the most recently written
//     entry and that entry is still queued.
//
// Ports
//   clk, reset_n      system clock, asynchronous active-low reset
//   usr_valid/action  user action offer
//   usr_ready         user action accepted when usr_valid && usr_ready
//   tmr_en            per-channel enable
//   tmr_restart       per-channel synchronous restart pulse
//   tmr_period        per-channel period in clk cycles, [i*TW +: TW]
//   tmr_action        per-channel action code to enqueue, [i*AW +: AW]
//   flush             synchronous queue/pending/overflow clear
//   pop               consume the head entry (ignored when empty)
//   q_valid/action    head entry
//   q_count           occupancy, 0..QSIZE
//   tmr_fire          one-cycle pulse per channel fire
//   overflow          sticky; set when a fire is lost
module action_tick_queue #(
    parameter int QSIZE = 16,
    parameter int AW    = 8,
    parameter int NCH   = 4,
    parameter int TW    = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   usr_valid,
    input  logic [AW-1:0]          usr_action,
    output logic                   usr_ready,
    input  logic [NCH-1:0]         tmr_en,
    input  logic [NCH-1:0]         tmr_restart,
    input  logic [NCH*TW-1:0]      tmr_period,
    input  logic [NCH*AW-1:0]      tmr_action,
    input  logic                   flush,
    input  logic                   pop,
    output logic                   q_valid,
    output logic [AW-1:0]          q_action,
    output logic [$clog2(QSIZE):0] q_count,
    output logic [NCH-1:0]         tmr_fire,
    output logic                   overflow
);

    localparam int PW = $clog2(QSIZE);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(QSIZE);

    logic [TW-1:0]  cnt [NCH];
    logic [NCH-1:0] ch_active;
    logic [NCH-1:0] ch_wrap;
    logic [NCH-1:0] fire_now;
    logic [NCH-1:0] pend;
    logic [NCH-1:0] tmr_sel;
    logic [NCH-1:0] svc_mask;
    logic [AW-1:0]  tmr_sel_action;
    logic [AW-1:0]  mem [QSIZE];
    logic [PW-1:0]  wptr;
    logic [PW-1:0]  rptr;
    logic           rdy_en;
    logic           pend_any;
    logic           q_full;
    logic           tmr_service;
    logic           tmr_drop;
    logic           usr_push;
    logic           push_en;
    logic [AW-1:0]  push_data;
    logic           pop_en;

    // ---------------- timer channels ----------------
    // Restart suppresses a fire that would otherwise occur in the same cycle.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            ch_active[i] = tmr_en[i] && (tmr_period[i*TW +: TW] != '0);
            ch_wrap[i]   = ch_active[i] && (cnt[i] == (tmr_period[i*TW +: TW] - TW'(1)));
            fire_now[i]  = ch_wrap[i] && !tmr_restart[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (!ch_active[i] || tmr_restart[i] || ch_wrap[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + TW'(1);
                end
            end
        end
    end

    // ---------------- enqueue arbitration ----------------
    // pend & -pend isolates the lowest-index pending channel as a one-hot mask.
    always_comb begin
        tmr_sel        = pend & (~pend + NCH'(1));
        tmr_sel_action = '0;
        for (int i = 0; i < NCH; i++) begin
            if (tmr_sel[i]) begin
                tmr_sel_action = tmr_action[i*AW +: AW];
            end
        end
    end

    assign pend_any    = |pend;
    assign q_full      = (q_count == FULL_CNT);
    assign q_valid     = (q_count != '0);
    assign usr_ready   = rdy_en && !pend_any && !q_full && !flush;
    assign tmr_service = pend_any && !q_full && !flush;
    assign svc_mask    = tmr_service ? tmr_sel : '0;
    assign usr_push    = usr_valid && usr_ready;

`ifdef ACTQ_COALESCE_EN
    logic [AW-1:0] last_act;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_act <= '0;
        end else if (push_en) begin
            last_act <= push_data;
        end
    end

    // Only meaningful while the last written entry is still queued.
    assign tmr_drop = tmr_service && (q_count != '0) && (tmr_sel_action == last_act);
`else
    assign tmr_drop = 1'b0;
`endif

    assign push_en   = (tmr_service && !tmr_drop) || usr_push;
    assign push_data = tmr_service ? tmr_sel_action : usr_action;
    assign pop_en    = pop && q_valid && !flush;

    // ---------------- pending / overflow / fire ----------------
    // A fire is lost only if its pend bit stays set through this cycle.
    // A bit serviced in the same cycle can take the new fire.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend     <= '0;
            overflow <= 1'b0;
            tmr_fire <= '0;
            rdy_en   <= 1'b0;
        end else begin
            tmr_fire <= fire_now;
            rdy_en   <= 1'b1;
            if (flush) begin
                pend     <= '0;
                overflow <= 1'b0;
            end else begin
                pend <= (pend & ~svc_mask & ~tmr_restart) | fire_now;
                if (|(fire_now & pend & ~svc_mask)) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    // ---------------- FIFO ----------------
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr    <= '0;
            rptr    <= '0;
            q_count <= '0;
        end else if (flush) begin
            wptr    <= '0;
            rptr    <= '0;
            q_count <= '0;
        end else begin
            if (push_en) begin
                wptr <= wptr + PW'(1);
            end
            if (pop_en) begin
                rptr <= rptr + PW'(1);
            end
            if (push_en && !pop_en) begin
                q_count <= q_count + CW'(1);
            end else if (pop_en && !push_en) begin
                q_count <= q_count - CW'(1);
            end
        end
    end

    assign q_action = q_valid ? mem[rptr] : '0;

endmodule

// File: tb/tb_action_tick_queue.sv
module tb_action_tick_queue;

    localparam int QSIZE = 16;
    localparam int AW    = 8;
    localparam int NCH   = 4;
    localparam int TW    = 32;

    logic              clk;
    logic              reset_n;
    logic              usr_valid;
    logic [AW-1:0]     usr_action;
    logic              usr_ready;
    logic [NCH-1:0]    tmr_en;
    logic [NCH-1:0]    tmr_restart;
    logic [NCH*TW-1:0] tmr_period;
    logic [NCH*AW-1:0] tmr_action;
    logic              flush;
    logic              pop;
    logic              q_valid;
    logic [AW-1:0]     q_action;
    logic [4:0]        q_count;
    logic [NCH-1:0]    tmr_fire;
    logic              overflow;

    action_tick_queue #(.QSIZE(QSIZE), .AW(AW), .NCH(NCH), .TW(TW)) dut (
        .clk(clk), .reset_n(reset_n),
        .usr_valid(usr_valid), .usr_action(usr_action), .usr_ready(usr_ready),
        .tmr_en(tmr_en), .tmr_restart(tmr_restart),
        .tmr_period(tmr_period), .tmr_action(tmr_action),
        .flush(flush), .pop(pop),
        .q_valid(q_valid), .q_action(q_action), .q_count(q_count),
        .tmr_fire(tmr_fire), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic       uv;
        logic [7:0] ua;
        logic       pp;
        logic       fl;
        logic       ev;
        logic [7:0] ea;
        logic [4:0] ec;
        logic       er;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic idle();
        usr_valid   = 1'b0;
        pop         = 1'b0;
        flush       = 1'b0;
        tmr_restart = '0;
    endtask

    // Advance one clock, release pulse inputs, then let outputs settle for sampling.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [31:0] period, input logic [7:0] act);
        tmr_period[ch*TW +: TW] = period;
        tmr_action[ch*AW +: AW] = act;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_q_valid"},   32'(q_valid),   32'h0);
        chk({tag, "_q_count"},   32'(q_count),   32'h0);
        chk({tag, "_q_action"},  32'(q_action),  32'h0);
        chk({tag, "_usr_ready"}, 32'(usr_ready), 32'h0);
        chk({tag, "_overflow"},  32'(overflow),  32'h0);
        chk({tag, "_tmr_fire"},  32'(tmr_fire),  32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fires;
        reset_n     = 1'b0;
        usr_action  = '0;
        tmr_en      = '0;
        tmr_period  = '0;
        tmr_action  = '0;
        idle();

        vecs[0]  = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 8'h04, 5'd1, 1'b1};
        vecs[1]  = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 8'h04, 5'd2, 1'b1};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h05, 5'd1, 1'b1};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1};
        vecs[5]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 5'd1, 1'b1};
        vecs[6]  = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 8'h22, 5'd1, 1'b1};
        vecs[7]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h22, 5'd2, 1'b1};
        vecs[8]  = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1};
        vecs[9]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h55, 5'd1, 1'b1};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        #3 reset_n = 1'b1;
        #1;
        chk("ready_before_first_edge", 32'(usr_ready), 32'h0);
        tick();
        chk("ready_after_release", 32'(usr_ready), 32'h1);

        // user-path vector table
        for (int v = 0; v < 11; v++) begin
            usr_valid  = vecs[v].uv;
            usr_action = vecs[v].ua;
            pop        = vecs[v].pp;
            flush      = vecs[v].fl;
            tick();
            chk($sformatf("vec%0d_q_valid", v),   32'(q_valid),   32'(vecs[v].ev));
            chk($sformatf("vec%0d_q_action", v),  32'(q_action),  32'(vecs[v].ea));
            chk($sformatf("vec%0d_q_count", v),   32'(q_count),   32'(vecs[v].ec));
            chk($sformatf("vec%0d_usr_ready", v), 32'(usr_ready), 32'(vecs[v].er));
        end

        // channel 0 period 5: fires after 5, 10, 15, 20 cycles
        set_ch(0, 32'd5, 8'h06);
        tmr_en = 4'b0001;
        for (int c = 1; c <= 20; c++) begin
            tick();
            chk($sformatf("p5_fire_c%0d", c), 32'(tmr_fire[0]), 32'(c % 5 == 0));
            if (c == 5)  chk("p5_ready_pending", 32'(usr_ready), 32'h0);
            if (c == 16) begin
                chk("p5_count_c16", 32'(q_count), 32'd3);
                chk("p5_head_c16", 32'(q_action), 32'h06);
            end
        end
        chk("p5_count_c20", 32'(q_count), 32'd3);
        chk("p5_ready_c20", 32'(usr_ready), 32'h0);

        // flush with 3 entries and pend[0] set; counter keeps running
        flush = 1'b1;
        tick();
        chk("flush_count", 32'(q_count), 32'd0);
        chk("flush_valid", 32'(q_valid), 32'h0);
        chk("flush_action", 32'(q_action), 32'h0);
        chk("flush_overflow", 32'(overflow), 32'h0);
        chk("flush_ready", 32'(usr_ready), 32'h1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("flush_cnt_runs_k%0d", k), 32'(tmr_fire[0]), 32'(k == 4));
        end
        tmr_en = '0;
        tick();
        chk("after_flush_push", 32'(q_count), 32'd1);
        flush = 1'b1;
        tick();

        // two channels firing in the same cycle
        set_ch(0, 32'd3, 8'h06);
        set_ch(1, 32'd3, 8'h0B);
        tmr_en = 4'b0011;
        repeat (3) tick();
        chk("dual_fire", 32'(tmr_fire), 32'h3);
        chk("dual_ready0", 32'(usr_ready), 32'h0);
        usr_valid = 1'b1; usr_action = 8'h77;
        tick();
        chk("dual_count1", 32'(q_count), 32'd1);
        chk("dual_head1", 32'(q_action), 32'h06);
        chk("dual_ready1", 32'(usr_ready), 32'h0);
        usr_valid = 1'b1; usr_action = 8'h77;
        tmr_en = '0;
        tick();
        chk("dual_count2", 32'(q_count), 32'd2);
        chk("dual_ready2", 32'(usr_ready), 32'h1);
        pop = 1'b1;
        tick();
        chk("dual_pop1_head", 32'(q_action), 32'h0B);
        chk("dual_pop1_count", 32'(q_count), 32'd1);
        pop = 1'b1;
        tick();
        chk("dual_pop2_valid", 32'(q_valid), 32'h0);

        // full queue: pending held, second fire lost
        for (int i = 0; i < 16; i++) begin
            usr_valid = 1'b1; usr_action = 8'(8'h40 + i);
            tick();
        end
        chk("full_count", 32'(q_count), 32'd16);
        chk("full_ready", 32'(usr_ready), 32'h0);
        chk("full_head", 32'(q_action), 32'h40);
        set_ch(0, 32'd2, 8'h06);
        tmr_en = 4'b0001;
        repeat (2) tick();
        chk("full_fire1", 32'(tmr_fire[0]), 32'h1);
        chk("full_ovf_after_fire1", 32'(overflow), 32'h0);
        chk("full_count_after_fire1", 32'(q_count), 32'd16);
        repeat (2) tick();
        chk("full_ovf_after_fire2", 32'(overflow), 32'h1);
        chk("full_count_after_fire2", 32'(q_count), 32'd16);
        tmr_en = '0;
        pop = 1'b1; usr_valid = 1'b1; usr_action = 8'h99;
        tick();
        chk("full_pop_count", 32'(q_count), 32'd15);
        chk("full_pop_head", 32'(q_action), 32'h41);
        tick();
        chk("full_pend_enters", 32'(q_count), 32'd16);
        chk("full_ovf_sticky", 32'(overflow), 32'h1);
        for (int k = 1; k <= 15; k++) begin
            pop = 1'b1;
            tick();
            chk($sformatf("drain_head_k%0d", k), 32'(q_action), (k < 15) ? 32'(8'h41 + k) : 32'h06);
            chk($sformatf("drain_count_k%0d", k), 32'(q_count), 32'(16 - k));
        end
        flush = 1'b1;
        tick();
        chk("flush_clears_ovf", 32'(overflow), 32'h0);
        chk("flush_clears_count", 32'(q_count), 32'd0);

        // restart beats a same-cycle fire and re-phases the counter
        set_ch(0, 32'd3, 8'h21);
        tmr_en = 4'b0001;
        repeat (2) tick();
        tmr_restart = 4'b0001;
        tick();
        chk("restart_no_fire", 32'(tmr_fire[0]), 32'h0);
        chk("restart_ready", 32'(usr_ready), 32'h1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("restart_rephase_k%0d", k), 32'(tmr_fire[0]), 32'(k == 3));
        end
        tmr_en = '0;
        tick();
        chk("restart_push_count", 32'(q_count), 32'd1);
        chk("restart_push_head", 32'(q_action), 32'h21);
        pop = 1'b1;
        tick();
        chk("restart_pop_empty", 32'(q_count), 32'd0);

        // period 2 for 10 cycles, then let the last pending entry land
        set_ch(0, 32'd2, 8'h06);
        tmr_en = 4'b0001;
        fires = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            fires += int'(tmr_fire[0]);
        end
        tmr_en = '0;
        tick();
        chk("p2_fire_pulses", 32'(fires), 32'd5);
`ifdef ACTQ_COALESCE_EN
        chk("p2_count", 32'(q_count), 32'd1);
`else
        chk("p2_count", 32'(q_count), 32'd5);
`endif
        chk("p2_overflow", 32'(overflow), 32'h0);
        chk("p2_head", 32'(q_action), 32'h06);

        // asynchronous reset mid-fill
        tmr_en = 4'b0001;
        repeat (3) tick();
        #2 reset_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        tmr_en = '0;
        #1 reset_n = 1'b1;
        tick();
        chk("post_rst_ready", 32'(usr_ready), 32'h1);
        chk("post_rst_count", 32'(q_count), 32'd0);
        chk("post_rst_valid", 32'(q_valid), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
